// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and default vectors for the fetch PC redirect unit.
package pc_redirect_unit_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam logic [31:0] INSN_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        PCG_BOOT,
        PCG_RUN,
        PCG_FLUSH
    } pcgen_state_t;

    typedef struct packed {
        logic            exec_valid;
        logic [XLEN-1:0] exec_pc;
        logic [XLEN-1:0] npc_op1;
        logic [XLEN-1:0] npc_op2;
        logic            is_branch;
        logic            is_jalr;
        logic            br_taken;
    } npc_req_t;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Execute-to-fetch redirect bus: next-PC request in, fetch control out.
interface pc_redirect_unit_if;
    import pc_redirect_unit_pkg::*;

    logic            stall;
    logic            exec_valid;
    logic [XLEN-1:0] exec_pc;
    logic [XLEN-1:0] npc_op1;
    logic [XLEN-1:0] npc_op2;
    logic            is_branch;
    logic            is_jalr;
    logic            br_taken;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_valid;
    logic            flush;
    logic            redirect;
    logic            exc_misaligned;
    logic [XLEN-1:0] exc_tval;

    modport master (
        output stall, exec_valid, exec_pc, npc_op1, npc_op2, is_branch, is_jalr, br_taken,
        input  fetch_pc, fetch_valid, flush, redirect, exc_misaligned, exc_tval
    );

    modport slave (
        input  stall, exec_valid, exec_pc, npc_op1, npc_op2, is_branch, is_jalr, br_taken,
        output fetch_pc, fetch_valid, flush, redirect, exc_misaligned, exc_tval
    );

endinterface

// File: rtl/pc_redirect_unit_branch_target_calc.sv
// Resolves the real next PC of the executed instruction against the sequential prediction.
module branch_target_calc
    import pc_redirect_unit_pkg::*;
(
    input  npc_req_t        req,
    output logic [XLEN-1:0] actual,
    output logic            mispredict,
    output logic            misalign
);

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq;

    always_comb begin
        target = req.npc_op1 + req.npc_op2;
        if (req.is_jalr) begin
            target[0] = 1'b0;
        end
        seq = req.exec_pc + INSN_BYTES;
        // Alignment is judged on the selected PC so a not-taken branch cannot trap.
        actual     = (req.is_branch && !req.br_taken) ? seq : target;
        mispredict = req.exec_valid && (actual != seq);
        misalign   = req.exec_valid && (actual[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with execute-driven redirect, timed IF/ID squash and misaligned-target trap.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    pc_redirect_unit_if.slave  bus
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    npc_req_t        req;
    logic [XLEN-1:0] actual;
    logic            mispredict;
    logic            misalign;

    pcgen_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic            redirect_q, redirect_nxt;
    logic            exc_q, exc_nxt;
    logic [XLEN-1:0] tval_q, tval_nxt;

    assign req = '{exec_valid: bus.exec_valid, exec_pc: bus.exec_pc,
                   npc_op1: bus.npc_op1, npc_op2: bus.npc_op2,
                   is_branch: bus.is_branch, is_jalr: bus.is_jalr,
                   br_taken: bus.br_taken};

    branch_target_calc u_btc (
        .req        (req),
        .actual     (actual),
        .mispredict (mispredict),
        .misalign   (misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PCG_BOOT;
            pc         <= RESET_VECTOR;
            cnt        <= '0;
            redirect_q <= 1'b0;
            exc_q      <= 1'b0;
            tval_q     <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            cnt        <= cnt_nxt;
            redirect_q <= redirect_nxt;
            exc_q      <= exc_nxt;
            tval_q     <= tval_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        cnt_nxt      = cnt;
        redirect_nxt = 1'b0;
        exc_nxt      = 1'b0;
        tval_nxt     = tval_q;
        case (state)
            PCG_BOOT: state_nxt = PCG_RUN;
            PCG_RUN, PCG_FLUSH: begin
                // A resolved redirect is honoured even mid-flush and restarts the bubble count.
                if (misalign) begin
                    pc_nxt    = TRAP_VECTOR;
                    exc_nxt   = 1'b1;
                    tval_nxt  = actual;
                    cnt_nxt   = FLUSH_LAST;
                    state_nxt = PCG_FLUSH;
                end else if (mispredict) begin
                    pc_nxt       = actual;
                    redirect_nxt = 1'b1;
                    cnt_nxt      = FLUSH_LAST;
                    state_nxt    = PCG_FLUSH;
                end else if (state == PCG_RUN) begin
                    if (!bus.stall) begin
                        pc_nxt = pc + INSN_BYTES;
                    end
                end else if (cnt == 3'd0) begin
                    state_nxt = PCG_RUN;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: state_nxt = PCG_BOOT;
        endcase
    end

    assign bus.fetch_pc       = pc;
    assign bus.fetch_valid    = (state == PCG_RUN);
    assign bus.flush          = (state == PCG_FLUSH);
    assign bus.redirect       = redirect_q;
    assign bus.exc_misaligned = exc_q;
    assign bus.exc_tval       = tval_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: directed execute requests with expected fetch state queued per cycle.
module tb_pc_redirect_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pc_redirect_unit_if bus ();

    pc_redirect_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        stall;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        br;
        logic        jalr;
        logic        tk;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic        f;
        logic        r;
        logic        x;
        logic [31:0] tval;
    } exp_t;

    exp_t  expq[$];
    string tagq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic stim_t idle();
        return '{stall: 1'b0, ev: 1'b0, epc: 32'h0, op1: 32'h0, op2: 32'h0, br: 1'b0, jalr: 1'b0, tk: 1'b0};
    endfunction

    function automatic stim_t stl();
        stim_t s = idle();
        s.stall = 1'b1;
        return s;
    endfunction

    function automatic stim_t jmp(input logic [31:0] epc, input logic [31:0] op1, input logic [31:0] op2);
        return '{stall: 1'b0, ev: 1'b1, epc: epc, op1: op1, op2: op2, br: 1'b0, jalr: 1'b0, tk: 1'b0};
    endfunction

    function automatic stim_t jalr(input logic [31:0] epc, input logic [31:0] op1, input logic [31:0] op2);
        stim_t s = jmp(epc, op1, op2);
        s.jalr = 1'b1;
        return s;
    endfunction

    function automatic stim_t brc(input logic [31:0] epc, input logic [31:0] op1, input logic [31:0] op2,
                                  input logic tk);
        stim_t s = jmp(epc, op1, op2);
        s.br = 1'b1;
        s.tk = tk;
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] pc, input logic v, input logic f, input logic r,
                                input logic x, input logic [31:0] tval);
        return '{pc: pc, v: v, f: f, r: r, x: x, tval: tval};
    endfunction

    // Drive one cycle of stimulus, queue the state expected after the edge, then score it.
    task automatic step(input string tag, input stim_t s, input exp_t e);
        exp_t  got;
        string t;
        bus.stall      = s.stall;
        bus.exec_valid = s.ev;
        bus.exec_pc    = s.epc;
        bus.npc_op1    = s.op1;
        bus.npc_op2    = s.op2;
        bus.is_branch  = s.br;
        bus.is_jalr    = s.jalr;
        bus.br_taken   = s.tk;
        expq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
        got = expq.pop_front();
        t   = tagq.pop_front();
        chk({t, ".pc"}, bus.fetch_pc, got.pc);
        chk({t, ".valid"}, 32'(bus.fetch_valid), 32'(got.v));
        chk({t, ".flush"}, 32'(bus.flush), 32'(got.f));
        chk({t, ".redirect"}, 32'(bus.redirect), 32'(got.r));
        chk({t, ".exc"}, 32'(bus.exc_misaligned), 32'(got.x));
        if (got.x) begin
            chk({t, ".tval"}, bus.exc_tval, got.tval);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.stall      = 1'b0;
        bus.exec_valid = 1'b0;
        bus.exec_pc    = '0;
        bus.npc_op1    = '0;
        bus.npc_op2    = '0;
        bus.is_branch  = 1'b0;
        bus.is_jalr    = 1'b0;
        bus.br_taken   = 1'b0;

        #22;
        chk("rst.pc", bus.fetch_pc, 32'h0);
        chk("rst.valid", 32'(bus.fetch_valid), 32'd0);
        chk("rst.flush", 32'(bus.flush), 32'd0);
        chk("rst.redirect", 32'(bus.redirect), 32'd0);
        chk("rst.exc", 32'(bus.exc_misaligned), 32'd0);
        chk("rst.tval", bus.exc_tval, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("boot.pc", bus.fetch_pc, 32'h0);
        chk("boot.valid", 32'(bus.fetch_valid), 32'd0);

        step("run0", idle(), ex(32'h0, 1, 0, 0, 0, 0));
        step("run4", idle(), ex(32'h4, 1, 0, 0, 0, 0));
        step("run8", idle(), ex(32'h8, 1, 0, 0, 0, 0));
        step("runC", idle(), ex(32'hC, 1, 0, 0, 0, 0));
        step("run10", idle(), ex(32'h10, 1, 0, 0, 0, 0));

        step("jal", jmp(32'h20, 32'h20, 32'h40), ex(32'h60, 0, 1, 1, 0, 0));
        step("jal.fl2", idle(), ex(32'h60, 0, 1, 0, 0, 0));
        step("jal.tgt", idle(), ex(32'h60, 1, 0, 0, 0, 0));
        step("jal.nxt", idle(), ex(32'h64, 1, 0, 0, 0, 0));

        step("beq.nt", brc(32'h30, 32'h30, 32'h100, 1'b0), ex(32'h68, 1, 0, 0, 0, 0));
        step("br.tk.seq", brc(32'h40, 32'h40, 32'h4, 1'b1), ex(32'h6C, 1, 0, 0, 0, 0));
        step("br.nt.odd", brc(32'h100, 32'h100, 32'h3, 1'b0), ex(32'h70, 1, 0, 0, 0, 0));

        step("jalr", jalr(32'h70, 32'h1001, 32'h4), ex(32'h1004, 0, 1, 1, 0, 0));
        step("jalr.fl2", idle(), ex(32'h1004, 0, 1, 0, 0, 0));
        step("jalr.tgt", idle(), ex(32'h1004, 1, 0, 0, 0, 0));
        step("jalr.nxt", idle(), ex(32'h1008, 1, 0, 0, 0, 0));

        step("trap", jalr(32'h1004, 32'h1002, 32'h0), ex(32'h100, 0, 1, 0, 1, 32'h1002));
        step("trap.fl2", idle(), ex(32'h100, 0, 1, 0, 0, 0));
        step("trap.vec", idle(), ex(32'h100, 1, 0, 0, 0, 0));
        step("trap.nxt", idle(), ex(32'h104, 1, 0, 0, 0, 0));

        step("wrap.jmp", jmp(32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'h20), ex(32'h10, 0, 1, 1, 0, 0));
        step("wrap.fl2", idle(), ex(32'h10, 0, 1, 0, 0, 0));
        step("wrap.tgt", idle(), ex(32'h10, 1, 0, 0, 0, 0));
        step("wrap.nt", brc(32'hFFFF_FFFC, 32'h0, 32'h8, 1'b0), ex(32'h14, 1, 0, 0, 0, 0));

        step("rf.first", jmp(32'h14, 32'h0, 32'h200), ex(32'h200, 0, 1, 1, 0, 0));
        step("rf.fl2", idle(), ex(32'h200, 0, 1, 0, 0, 0));
        step("rf.again", jmp(32'h200, 32'h0, 32'h500), ex(32'h500, 0, 1, 1, 0, 0));
        step("rf.fl2b", idle(), ex(32'h500, 0, 1, 0, 0, 0));
        step("rf.tgt", idle(), ex(32'h500, 1, 0, 0, 0, 0));

        step("st.jmp", jmp(32'h500, 32'h0, 32'h40), ex(32'h40, 0, 1, 1, 0, 0));
        step("st.fl2", idle(), ex(32'h40, 0, 1, 0, 0, 0));
        step("st.at40", idle(), ex(32'h40, 1, 0, 0, 0, 0));
        step("st.c1", stl(), ex(32'h40, 1, 0, 0, 0, 0));
        begin
            stim_t s = brc(32'h38, 32'h38, 32'h48, 1'b1);
            s.stall = 1'b1;
            step("st.c2.br", s, ex(32'h80, 0, 1, 1, 0, 0));
        end
        step("st.c3", stl(), ex(32'h80, 0, 1, 0, 0, 0));
        step("st.flend", stl(), ex(32'h80, 1, 0, 0, 0, 0));
        step("st.nxt", idle(), ex(32'h84, 1, 0, 0, 0, 0));

        step("ar.jmp", jmp(32'h84, 32'h0, 32'h300), ex(32'h300, 0, 1, 1, 0, 0));
        #3;
        rst = 1'b1;
        #1;
        chk("ar.pc", bus.fetch_pc, 32'h0);
        chk("ar.flush", 32'(bus.flush), 32'd0);
        chk("ar.valid", 32'(bus.fetch_valid), 32'd0);
        chk("ar.redirect", 32'(bus.redirect), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar.boot.pc", bus.fetch_pc, 32'h0);
        chk("ar.boot.valid", 32'(bus.fetch_valid), 32'd0);
        step("ar.run0", idle(), ex(32'h0, 1, 0, 0, 0, 0));
        step("ar.run4", idle(), ex(32'h4, 1, 0, 0, 0, 0));

        chk("sb.empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side consumer of the execute stage's next-PC operand pair (npc_op1/npc_op2) and the ALU branch outcome.
- Owns the architectural fetch PC register and resolves the actual next PC of each executed instruction.
- On a redirect it steers fetch to the new target, squashes the younger instructions in IF/ID for a fixed number of cycles, and traps on misaligned targets.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, fetch address after a misaligned-target trap.
- FLUSH_CYCLES, 2, bubble cycles inserted after a redirect (range 1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit hold; the PC does not advance.
- exec_valid  in  1  the execute-stage instruction is valid this cycle.
- exec_pc  in  32  PC of the execute-stage instruction.
- npc_op1  in  32  next-PC operand 1 from execute.
- npc_op2  in  32  next-PC operand 2 from execute.
- is_branch  in  1  the instruction is a conditional branch (BEQ..BGEU).
- is_jalr  in  1  the instruction is JALR; clear bit 0 of the target.
- br_taken  in  1  ALU branch condition is true.
- fetch_pc  out  32  address presented to instruction memory.
- fetch_valid  out  1  fetch_pc is a real fetch; 0 during a bubble.
- flush  out  1  kill the IF/ID contents this cycle.
- redirect  out  1  one-cycle pulse: fetch_pc was loaded from execute.
- exc_misaligned  out  1  one-cycle pulse: the target was not 4-byte aligned.
- exc_tval  out  32  offending target; valid while exc_misaligned=1.

Behaviour:
- Reset (asynchronous, any state):
  - fetch_pc=RESET_VECTOR, state=BOOT.
  - fetch_valid=0, flush=0, redirect=0, exc_misaligned=0, exc_tval=0, flush counter=0.
- Combinational target:
  - target = npc_op1+npc_op2, 32-bit wrap-around with no carry out.
  - If is_jalr, target[0] is forced to 0.
- Sequential next PC: seq = exec_pc+4, with wrap-around.
- Actual next PC: actual = (is_branch && !br_taken) ? seq : target.
- mispredict = exec_valid && (actual != seq). Fetch always predicts sequential.
- misalign = exec_valid && (actual[1:0] != 0). This check is made on the selected actual value, so a not-taken branch never traps.
- States:
  - BOOT: one cycle. fetch_valid=0. Next state RUN. fetch_pc stays RESET_VECTOR.
  - RUN:
    - fetch_valid=1.
    - Priority order: misalign > mispredict > stall > advance.
    - misalign: fetch_pc<=TRAP_VECTOR, exc_misaligned=1, exc_tval=actual, flush=1, go to FLUSH.
    - mispredict: fetch_pc<=actual, redirect=1, flush=1, go to FLUSH.
    - stall with no redirect: fetch_pc holds.
    - otherwise: fetch_pc<=fetch_pc+4.
  - FLUSH:
    - fetch_valid=0, flush=1, fetch_pc holds.
    - The counter counts FLUSH_CYCLES-1 further cycles, then the state returns to RUN.
    - stall is ignored; the bubble count is time-based.
- Latency: a redirect is visible on fetch_pc the cycle after exec_valid. The first valid fetch of the target occurs FLUSH_CYCLES cycles after the redirect pulse.
- Redirect vs stall in the same cycle: the redirect wins. A resolved branch is never lost.
- exec_valid=1 while in FLUSH means a bench or pipeline error. It is still honoured: the new redirect or trap reloads fetch_pc, restarts the counter, and pulses redirect or exc_misaligned.
- Outputs redirect and exc_misaligned are registered pulses, high for exactly one cycle.
- Reset asserted mid-FLUSH aborts the flush immediately. BOOT is re-entered on deassertion.

Decomposition:
- Add to PipelineTypes: enum PcGenState {PCG_BOOT, PCG_RUN, PCG_FLUSH}, and a struct NpcReq bundling exec_valid, exec_pc, npc_op1, npc_op2, is_branch, is_jalr, br_taken.
- Add RESET_VECTOR and TRAP_VECTOR defaults to BasicTypes.
- One combinational sub-module, branch_target_calc: takes NpcReq and produces actual, mispredict and misalign.
- The FSM, flush counter and PC register stay in the top module.

Test Plan:
- Reset released, no exec activity -> BOOT cycle with fetch_pc=0, fetch_valid=0; then fetch_pc 0,4,8,C on consecutive cycles with fetch_valid=1.
- JAL: exec_pc=0x20, op1=0x20, op2=0x40 -> next cycle fetch_pc=0x60 and redirect=1; flush=1 for 2 cycles; 0x60 fetched valid on cycle 3; then 0x64.
- BEQ not taken: exec_pc=0x30, op1=0x30, op2=0x100, br_taken=0 -> no redirect; fetch_pc continues sequentially.
- JALR: op1=0x1001, op2=0x4 -> target 0x1004 (bit0 cleared then aligned), redirect. Separately op1=0x1002, op2=0 -> exc_misaligned=1, exc_tval=0x1002, fetch_pc=0x100.
- Stall held 3 cycles at fetch_pc=0x40 with a taken branch to 0x80 arriving in stall cycle 2 -> fetch_pc=0x80 the next cycle (redirect overrides stall).
- Reset asserted asynchronously mid-FLUSH -> fetch_pc=0 and flush=0 immediately, without waiting for a clock edge; BOOT follows deassertion.
